zap_ram_fifo_ctrl: RTL and testbench

ZAP_RAM_FIFO_CTRL -- requirements
Module: zap_ram_fifo_ctrl

---
 rtl/zap_ram_fifo_ctrl_if.sv | 38 +++
 rtl/zap_ram_fifo_ctrl.sv | 71 +++++++
 tb/tb_zap_ram_fifo_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/zap_ram_fifo_ctrl_if.sv
// Push/pop side and external 1R+1W RAM side of the RAM-backed FIFO controller.
// slave = controller, master = client that owns the requests and the RAM.
interface zap_ram_fifo_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             i_flush;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             o_full;
    logic             i_rd_en;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_valid;
    logic [AW:0]      o_level;
    logic             o_overflow;
    logic             o_underflow;

    logic             o_ram_wr_en;
    logic [AW-1:0]    o_ram_wr_addr;
    logic [WIDTH-1:0] o_ram_wr_data;
    logic             o_ram_rd_en;
    logic [AW-1:0]    o_ram_rd_addr;
    logic [WIDTH-1:0] i_ram_rd_data;

    modport slave (
        input  i_flush, i_wr_en, i_wr_data, i_rd_en, i_ram_rd_data,
        output o_full, o_rd_data, o_valid, o_level, o_overflow, o_underflow,
        output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_rd_en, o_ram_rd_addr
    );

    modport master (
        output i_flush, i_wr_en, i_wr_data, i_rd_en, i_ram_rd_data,
        input  o_full, o_rd_data, o_valid, o_level, o_overflow, o_underflow,
        input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_rd_en, o_ram_rd_addr
    );
endinterface

// File: rtl/zap_ram_fifo_ctrl.sv
// FWFT FIFO controller over an external 1-cycle-latency RAM; push visible two edges later.
// Pushes refused when RAM holds DEPTH words, pops refused with no head word (both flagged next cycle).
module zap_ram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    zap_ram_fifo_ctrl_if.slave   bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_cnt;
    logic             valid_q;
    logic             ovf_q;
    logic             unf_q;

    logic             full;
    logic             push;
    logic             pop;
    logic             fetch;
    logic             quiet;
    logic [WIDTH-1:0] head_dat;

    assign full  = (ram_cnt == CNT_FULL);
    assign push  = bus.i_wr_en & ~full;
    assign pop   = bus.i_rd_en & valid_q;
    // Refill the head slot when it is empty or being consumed this cycle.
    assign fetch = (ram_cnt != '0) & (~valid_q | pop);
    assign quiet = i_reset | bus.i_flush;

    assign bus.o_ram_wr_en   = push & ~quiet;
    assign bus.o_ram_wr_addr = wr_ptr;
    assign bus.o_ram_wr_data = bus.i_wr_data;
    assign bus.o_ram_rd_en   = fetch & ~quiet;
    assign bus.o_ram_rd_addr = rd_ptr;

    assign head_dat      = bus.i_ram_rd_data;
    assign bus.o_rd_data = head_dat;

    assign bus.o_full      = full;
    assign bus.o_valid     = valid_q;
    assign bus.o_level     = ram_cnt + {{AW{1'b0}}, valid_q};
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, fetch};
            valid_q <= fetch | (valid_q & ~pop);
            ovf_q   <= bus.i_wr_en & full;
            unf_q   <= bus.i_rd_en & ~valid_q;
        end
    end
endmodule

// File: tb/tb_zap_ram_fifo_ctrl.sv
// Directed + randomized check of zap_ram_fifo_ctrl against a queue model with an attached RAM model.
module tb_zap_ram_fifo_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zap_ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    zap_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // External RAM: synchronous write, 1-cycle read latency, output held when not reading.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.o_ram_wr_en) mem[bus.o_ram_wr_addr] <= bus.o_ram_wr_data;
        if (bus.o_ram_rd_en) ram_q <= mem[bus.o_ram_rd_addr];
    end
    assign bus.i_ram_rd_data = ram_q;

    // Reference model: every stored word with the edge at which it was accepted.
    // A word becomes the visible head once it is at the front and was accepted
    // at least one edge before the latest edge.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               e;
    } ent_t;
    ent_t q[$];
    int   edge_n = 0;
    int   wcount = 0;
    bit   e_ovf  = 0;
    bit   e_unf  = 0;

    int total = 0;
    int bad   = 0;

    function automatic bit model_valid();
        return (q.size() > 0) && (q[0].e < edge_n);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check RAM-port outputs, advance model, check visible outputs.
    task automatic step(input logic r, input logic fl, input logic wr,
                        input logic [WIDTH-1:0] d, input logic rd);
        bit   mv, mfull, mpush, mpop;
        ent_t en;
        rst          = r;
        bus.i_flush  = fl;
        bus.i_wr_en  = wr;
        bus.i_wr_data = d;
        bus.i_rd_en  = rd;
        #1;
        mv    = model_valid();
        mfull = ((q.size() - (mv ? 1 : 0)) == DEPTH);
        mpush = wr && !mfull;
        mpop  = rd && mv;
        chk("ram_wr_en", bus.o_ram_wr_en, mpush && !r && !fl);
        if (mpush && !r && !fl) begin
            chk("ram_wr_addr", bus.o_ram_wr_addr, wcount % DEPTH);
            chk("ram_wr_data", bus.o_ram_wr_data, d);
        end
        if (r || fl) chk("ram_rd_en_quiet", bus.o_ram_rd_en, 0);
        @(posedge clk);
        edge_n++;
        if (r || fl) begin
            q.delete();
            wcount = 0;
            e_ovf  = 0;
            e_unf  = 0;
        end else begin
            e_ovf = wr && mfull;
            e_unf = rd && !mv;
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                en.d = d;
                en.e = edge_n;
                q.push_back(en);
                wcount++;
            end
        end
        @(negedge clk);
        chk("level", bus.o_level, q.size());
        chk("valid", bus.o_valid, model_valid());
        chk("full", bus.o_full, (q.size() - (model_valid() ? 1 : 0)) == DEPTH);
        chk("overflow", bus.o_overflow, e_ovf);
        chk("underflow", bus.o_underflow, e_unf);
        if (model_valid()) chk("rd_data", bus.o_rd_data, q[0].d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0);
    endtask

    int ovf_seen;
    int wrp, rdp;

    initial begin
        bus.i_flush   = 0;
        bus.i_wr_en   = 0;
        bus.i_wr_data = '0;
        bus.i_rd_en   = 0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, '0, 0);
        step(1, 0, 1, 32'hDEAD, 1);
        chk("rst_level", bus.o_level, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_full", bus.o_full, 0);
        chk("rst_ovf", bus.o_overflow, 0);
        chk("rst_unf", bus.o_underflow, 0);

        // Single word latency
        step(0, 0, 1, 32'hA1, 0);
        chk("lat_valid_n", bus.o_valid, 0);
        idle(1);
        chk("lat_valid_n1", bus.o_valid, 1);
        chk("lat_data", bus.o_rd_data, 32'hA1);
        chk("lat_level", bus.o_level, 1);
        step(0, 0, 0, '0, 1);
        chk("lat_pop_level", bus.o_level, 0);

        // Fill past capacity
        step(1, 0, 0, '0, 0);
        ovf_seen = 0;
        for (int i = 0; i < 34; i++) begin
            step(0, 0, 1, i, 0);
            if (bus.o_overflow) ovf_seen++;
        end
        chk("fill_full", bus.o_full, 1);
        chk("fill_level", bus.o_level, 33);
        chk("fill_ovf_count", ovf_seen, 1);
        idle(1);
        chk("fill_ovf_clear", bus.o_overflow, 0);

        // Drain from full, no bubbles
        for (int i = 0; i < 33; i++) begin
            chk("drain_valid", bus.o_valid, 1);
            chk("drain_seq", bus.o_rd_data, i);
            step(0, 0, 0, '0, 1);
        end
        chk("drain_valid_end", bus.o_valid, 0);
        chk("drain_level_end", bus.o_level, 0);

        // Steady push+pop at level 5 across pointer wrap
        for (int i = 0; i < 5; i++) step(0, 0, 1, 100 + i, 0);
        idle(2);
        for (int i = 0; i < 100; i++) begin
            chk("stream_data", bus.o_rd_data, (i < 5) ? 100 + i : 200 + i - 5);
            step(0, 0, 1, 200 + i, 1);
            chk("stream_level", bus.o_level, 5);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);
        chk("stream_empty", bus.o_level, 0);

        // Underflow pulse; pointer continuity checked on the following push
        step(0, 0, 0, '0, 1);
        chk("unf_pulse", bus.o_underflow, 1);
        idle(1);
        chk("unf_once", bus.o_underflow, 0);
        step(0, 0, 1, 32'h77, 0);
        idle(2);
        step(0, 0, 0, '0, 1);

        // Flush with a concurrent push
        for (int i = 0; i < 10; i++) step(0, 0, 1, 300 + i, 0);
        idle(2);
        chk("flush_pre_level", bus.o_level, 10);
        step(0, 1, 1, 32'hEE, 1);
        chk("flush_level", bus.o_level, 0);
        chk("flush_valid", bus.o_valid, 0);
        step(0, 0, 1, 32'h55, 0);
        idle(1);
        chk("flush_readback", bus.o_rd_data, 32'h55);
        chk("flush_rb_valid", bus.o_valid, 1);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(0, 0, 1, 400 + i, 0);
        step(1, 0, 1, 32'hBAD, 1);
        chk("midrst_level", bus.o_level, 0);
        idle(2);
        chk("midrst_valid", bus.o_valid, 0);

        // Randomized traffic in phases of varying fill pressure
        for (int c = 0; c < 800; c++) begin
            case (c / 200)
                0: begin wrp = 60; rdp = 50; end
                1: begin wrp = 92; rdp = 10; end
                2: begin wrp = 15; rdp = 85; end
                default: begin wrp = 50; rdp = 50; end
            endcase
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 99) < wrp),
                 $urandom,
                 ($urandom_range(0, 99) < rdp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
